// File: rtl/bcd_pkg.sv
// Shared constants, FSM encodings and helpers for the digit-serial BCD subtractor.
package bcd_pkg;

    localparam int         DIGIT_W  = 4;
    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam int         BCD_BASE = 10;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SUB  = 2'd1;
    localparam logic [1:0] COMP = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    function automatic logic is_bcd_digit(input logic [3:0] nibble);
        return nibble <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_serial_subtractor_if.sv
// Operand/result handshake bundle between the subtractor and its producer/consumer.
interface bcd_serial_subtractor_if #(
    parameter int DIGITS = 4
);

    logic                  in_valid;
    logic                  in_ready;
    logic [4*DIGITS-1:0]   a;
    logic [4*DIGITS-1:0]   b;
    logic                  res_valid;
    logic                  res_ready;
    logic [4*DIGITS-1:0]   result;
    logic                  negative;
    logic                  invalid;

    modport master (
        output in_valid, a, b, res_ready,
        input  in_ready, res_valid, result, negative, invalid
    );

    modport slave (
        input  in_valid, a, b, res_ready,
        output in_ready, res_valid, result, negative, invalid
    );

endinterface

// File: rtl/bcd_digit_sub.sv
// One BCD digit slice: d = x - y - borrow_in, wrapped back into 0..9 with a borrow out.
module bcd_digit_sub
    import bcd_pkg::*;
(
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       borrow_in,
    output logic [3:0] d,
    output logic       borrow_out
);

    logic [4:0] diff;

    // The 5-bit difference spans -10..9, so bit 4 is exactly the "went negative" flag.
    always_comb begin
        diff       = {1'b0, x} - {1'b0, y} - {4'b0000, borrow_in};
        borrow_out = diff[4];
        d          = borrow_out ? diff[3:0] + 4'(BCD_BASE) : diff[3:0];
    end

endmodule

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial BCD A-B with sign-magnitude result; one shared digit slice walks LSD first,
// then re-walks the result to take the ten's complement when the final borrow says A < B.
module bcd_serial_subtractor
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    bcd_serial_subtractor_if.slave  bus
);

    localparam int                W        = DIGIT_W * DIGITS;
    localparam int                IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DIGITS - 1);

    logic [1:0]       state;
    logic [W-1:0]     a_reg;
    logic [W-1:0]     b_reg;
    logic [W-1:0]     result_reg;
    logic [IDX_W-1:0] index;
    logic             borrow;
    logic             check_fail;
    logic             negative_reg;
    logic             invalid_reg;

    logic             inputs_bad;
    logic [3:0]       x_mux;
    logic [3:0]       y_mux;
    logic [3:0]       d;
    logic             borrow_out;

    always_comb begin
        inputs_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!is_bcd_digit(bus.a[i*DIGIT_W +: DIGIT_W]) ||
                !is_bcd_digit(bus.b[i*DIGIT_W +: DIGIT_W]))
                inputs_bad = 1'b1;
        end
    end

    // SUB feeds a_i - b_i; COMP feeds 0 - r_i to complement the stored result in place.
    always_comb begin
        x_mux = 4'd0;
        y_mux = result_reg[index*DIGIT_W +: DIGIT_W];
        if (state == SUB) begin
            x_mux = a_reg[index*DIGIT_W +: DIGIT_W];
            y_mux = b_reg[index*DIGIT_W +: DIGIT_W];
        end
    end

    bcd_digit_sub u_digit_sub (
        .x          (x_mux),
        .y          (y_mux),
        .borrow_in  (borrow),
        .d          (d),
        .borrow_out (borrow_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            a_reg        <= '0;
            b_reg        <= '0;
            result_reg   <= '0;
            index        <= '0;
            borrow       <= 1'b0;
            check_fail   <= 1'b0;
            negative_reg <= 1'b0;
            invalid_reg  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_reg        <= bus.a;
                        b_reg        <= bus.b;
                        result_reg   <= '0;
                        index        <= '0;
                        borrow       <= 1'b0;
                        negative_reg <= 1'b0;
                        invalid_reg  <= 1'b0;
                        check_fail   <= inputs_bad;
                        state        <= SUB;
                    end
                end
                SUB: begin
                    // A bad nibble skips the digit walk entirely and reports with a zero result.
                    if (check_fail) begin
                        invalid_reg <= 1'b1;
                        state       <= DONE;
                    end else begin
                        result_reg[index*DIGIT_W +: DIGIT_W] <= d;
                        if (index == LAST_IDX) begin
                            index  <= '0;
                            borrow <= 1'b0;
                            if (borrow_out) begin
                                negative_reg <= 1'b1;
                                state        <= COMP;
                            end else begin
                                state        <= DONE;
                            end
                        end else begin
                            index  <= index + 1'b1;
                            borrow <= borrow_out;
                        end
                    end
                end
                COMP: begin
                    result_reg[index*DIGIT_W +: DIGIT_W] <= d;
                    if (index == LAST_IDX) begin
                        index  <= '0;
                        borrow <= 1'b0;
                        state  <= DONE;
                    end else begin
                        index  <= index + 1'b1;
                        borrow <= borrow_out;
                    end
                end
                DONE: begin
                    if (bus.res_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.res_valid = (state == DONE);
    assign bus.result    = result_reg;
    assign bus.negative  = negative_reg;
    assign bus.invalid   = invalid_reg;

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Directed-vector bench for bcd_serial_subtractor (DIGITS=4): table loop plus
// backpressure and mid-operation reset sequences.
module tb_bcd_serial_subtractor;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    bcd_serial_subtractor_if #(.DIGITS(4)) bus ();

    bcd_serial_subtractor #(.DIGITS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_result;
        logic        exp_negative;
        logic        exp_invalid;
        int          exp_latency;
        string       name;
    } vec_t;

    vec_t vectors[$];
    int   assertions = 0;
    int   failures   = 0;
    int   latency;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Entered #1 after a rising edge; returns #1 after the accept edge.
    task automatic apply_stimulus(input logic [15:0] a, input logic [15:0] b);
        int waited = 0;
        while (!bus.in_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        check_output("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
        bus.a        = a;
        bus.b        = b;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!bus.res_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic handoff();
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
        check_output("res_valid_after_handoff", 32'(bus.res_valid), 32'd0);
        check_output("in_ready_after_handoff", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic run_vector(input vec_t v);
        int lat;
        apply_stimulus(v.a, v.b);
        wait_result(lat);
        check_output({v.name, "_latency"}, 32'(lat), 32'(v.exp_latency));
        check_output({v.name, "_result"}, 32'(bus.result), 32'(v.exp_result));
        check_output({v.name, "_negative"}, 32'(bus.negative), 32'(v.exp_negative));
        check_output({v.name, "_invalid"}, 32'(bus.invalid), 32'(v.exp_invalid));
        handoff();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.res_ready = 1'b0;

        vectors.push_back(vec_t'{16'h1234, 16'h0567, 16'h0667, 1'b0, 1'b0, 4, "pos_diff"});
        vectors.push_back(vec_t'{16'h0567, 16'h1234, 16'h0667, 1'b1, 1'b0, 8, "neg_diff"});
        vectors.push_back(vec_t'{16'h0000, 16'h0001, 16'h0001, 1'b1, 1'b0, 8, "zero_minus_one"});
        vectors.push_back(vec_t'{16'h5000, 16'h5000, 16'h0000, 1'b0, 1'b0, 4, "equal"});
        vectors.push_back(vec_t'{16'h12A4, 16'h0001, 16'h0000, 1'b0, 1'b1, 1, "bad_a"});
        vectors.push_back(vec_t'{16'h0000, 16'h00F0, 16'h0000, 1'b0, 1'b1, 1, "bad_b"});
        vectors.push_back(vec_t'{16'h0001, 16'h9999, 16'h9998, 1'b1, 1'b0, 8, "max_neg"});
        vectors.push_back(vec_t'{16'h9999, 16'h0000, 16'h9999, 1'b0, 1'b0, 4, "minus_zero"});

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_output("reset_in_ready", 32'(bus.in_ready), 32'd1);
        check_output("reset_res_valid", 32'(bus.res_valid), 32'd0);
        check_output("reset_result", 32'(bus.result), 32'd0);
        check_output("reset_negative", 32'(bus.negative), 32'd0);
        check_output("reset_invalid", 32'(bus.invalid), 32'd0);

        for (int i = 0; i < vectors.size(); i++)
            run_vector(vectors[i]);

        // Backpressure: result must hold and new operands must wait for the handoff.
        apply_stimulus(16'h1234, 16'h0567);
        wait_result(latency);
        check_output("bp_latency", 32'(latency), 32'd4);
        bus.a        = 16'h9999;
        bus.b        = 16'h0001;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check_output("bp_res_valid_held", 32'(bus.res_valid), 32'd1);
            check_output("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
            check_output("bp_result_held", 32'(bus.result), 32'h0667);
            check_output("bp_negative_held", 32'(bus.negative), 32'd0);
        end
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
        check_output("bp_release_res_valid", 32'(bus.res_valid), 32'd0);
        check_output("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check_output("bp_accepted", 32'(bus.in_ready), 32'd0);
        wait_result(latency);
        check_output("bp_next_latency", 32'(latency), 32'd4);
        check_output("bp_next_result", 32'(bus.result), 32'h9998);
        check_output("bp_next_negative", 32'(bus.negative), 32'd0);
        handoff();

        // Reset in the middle of SUB, while digit 2 is pending.
        apply_stimulus(16'h5678, 16'h1111);
        @(posedge clk);
        @(posedge clk); #1;
        check_output("midreset_partial", 32'(bus.result), 32'h0067);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("midreset_result", 32'(bus.result), 32'd0);
        check_output("midreset_res_valid", 32'(bus.res_valid), 32'd0);
        check_output("midreset_negative", 32'(bus.negative), 32'd0);
        check_output("midreset_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_output("postreset_in_ready", 32'(bus.in_ready), 32'd1);
        check_output("postreset_res_valid", 32'(bus.res_valid), 32'd0);
        run_vector(vec_t'{16'h9999, 16'h0001, 16'h9998, 1'b0, 1'b0, 4, "after_reset"});

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
